// File: rtl/wb_mem_ctrl.sv
// Wishbone memory-side stage: serves slave strobes from a word-addressed SRAM with programmable wait states.
// Optional posted writes are compiled in with `define MEM_POSTED_WR_EN.
module wb_mem_ctrl #(
  parameter int              ADDR_W      = 26,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH_LOG2  = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_STATES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] mem_adr_i,
  input  logic              mem_r_i,
  input  logic              mem_w_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              rdy_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [2:0]        fsm_state
);

  // Handshake: mem_r_i/mem_w_i are levels held by the slave until rdy_o; rdy_o (with err_o on
  // failure) pulses for one cycle, and the request must drop before another access is accepted.

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, DONE, RELEASE} state_t;

  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(2**DEPTH_LOG2);

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_W-1:0]       adr_q;
  logic [DATA_W-1:0]       wdat_q;
  logic                    rd_q;
  logic                    wr_q;
  logic                    err_q;
  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

  logic [ADDR_W-1:0]       off_q;
  logic                    hit_q;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    setup_ok;
  logic                    enter_access;
  logic                    post_ok;
  logic                    post_pend;

  assign off_q    = adr_q - BASE_ADDR;
  assign hit_q    = (adr_q >= BASE_ADDR) && ({1'b0, off_q} < SPAN);
  assign idx      = off_q[DEPTH_LOG2-1:0];
  assign setup_ok = !(rd_q && wr_q) && hit_q;

  // The array is touched only on the edge that moves the FSM into DONE.
  assign enter_access = ((state == SETUP) && setup_ok && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd1));

  assign fsm_state = state;
  assign busy_o    = (state != IDLE) || post_pend;

`ifdef MEM_POSTED_WR_EN
  logic [ADDR_W-1:0]     off_in;
  logic                  hit_in;
  logic [4:0]            post_cnt;
  logic [DEPTH_LOG2-1:0] post_idx;
  logic [DATA_W-1:0]     post_dat;
  logic                  post_commit;

  assign off_in      = mem_adr_i - BASE_ADDR;
  assign hit_in      = (mem_adr_i >= BASE_ADDR) && ({1'b0, off_in} < SPAN);
  assign post_ok     = mem_w_i && !mem_r_i && hit_in;
  assign post_commit = post_pend && (post_cnt == 5'd0);

  // Counter is loaded so the commit lands WAIT_STATES+2 edges after acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      post_pend <= 1'b0;
      post_cnt  <= '0;
      post_idx  <= '0;
      post_dat  <= '0;
    end else if ((state == IDLE) && !post_pend && post_ok) begin
      post_pend <= 1'b1;
      post_cnt  <= 5'(WAIT_STATES + 1);
      post_idx  <= off_in[DEPTH_LOG2-1:0];
      post_dat  <= dat_i;
    end else if (post_pend) begin
      if (post_cnt == 5'd0) post_pend <= 1'b0;
      else                  post_cnt  <= post_cnt - 5'd1;
    end
  end
`else
  assign post_ok   = 1'b0;
  assign post_pend = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (enter_access && wr_q) mem[idx] <= wdat_q;
`ifdef MEM_POSTED_WR_EN
    else if (post_commit) mem[post_idx] <= post_dat;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      dat_o  <= '0;
      rdy_o  <= 1'b0;
      err_o  <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rdy_o <= (state == DONE);
      err_o <= (state == DONE) && err_q;
      case (state)
        IDLE: begin
          if ((mem_r_i || mem_w_i) && !post_pend) begin
            adr_q  <= mem_adr_i;
            wdat_q <= dat_i;
            rd_q   <= mem_r_i;
            wr_q   <= mem_w_i;
            err_q  <= 1'b0;
            state  <= post_ok ? DONE : SETUP;
          end
        end
        SETUP: begin
          if (!setup_ok) begin
            err_q <= 1'b1;
            dat_o <= '0;
            state <= DONE;
          end else if (WAIT_STATES == 0) begin
            if (rd_q) dat_o <= mem[idx];
            state <= DONE;
          end else begin
            cnt   <= 4'(WAIT_STATES);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (rd_q) dat_o <= mem[idx];
            state <= DONE;
          end
        end
        DONE:    state <= RELEASE;
        RELEASE: if (!mem_r_i && !mem_w_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Directed bench for wb_mem_ctrl with default parameters (WAIT_STATES=2, 256 words at base 0).
module tb_wb_mem_ctrl;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LAT = 4;      // 2 + WAIT_STATES
  localparam int ERR_LAT = 2;
`ifdef MEM_POSTED_WR_EN
  localparam int WR_LAT = 1;
`else
  localparam int WR_LAT = LAT;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_adr = '0;
  logic          mem_r = 1'b0;
  logic          mem_w = 1'b0;
  logic [DW-1:0] dat_in = '0;
  logic [DW-1:0] dat_out;
  logic          rdy;
  logic          err;
  logic          busy;
  logic [2:0]    fsm_state;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [256];

  wb_mem_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .mem_adr_i (mem_adr),
    .mem_r_i   (mem_r),
    .mem_w_i   (mem_w),
    .dat_i     (dat_in),
    .dat_o     (dat_out),
    .rdy_o     (rdy),
    .err_o     (err),
    .busy_o    (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers: present a request, wait (bounded) for rdy, then drop it and let RELEASE finish
  task automatic access(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic e, output logic [DW-1:0] q);
    @(negedge clk);
    mem_r = r; mem_w = w; mem_adr = a; dat_in = d;
    lat = -1; e = 1'bx; q = 'x;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rdy) begin
        lat = k; e = err; q = dat_out;
        break;
      end
    end
    @(negedge clk);
    mem_r = 1'b0; mem_w = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_word(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat; logic e; logic [DW-1:0] q;
    access(1'b0, 1'b1, a, d, lat, e, q);
    check({tag, "_lat"}, 64'(lat), 64'(WR_LAT));
    check({tag, "_err"}, {63'd0, e}, 64'd0);
    model[a[7:0]] = d;
`ifdef MEM_POSTED_WR_EN
    repeat (3) @(posedge clk);
    #1;
`endif
  endtask

  task automatic read_word(input string tag, input logic [AW-1:0] a, input int exp_lat);
    int lat; logic e; logic [DW-1:0] q;
    exp_q.push_back(model[a[7:0]]);
    access(1'b1, 1'b0, a, '0, lat, e, q);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, {63'd0, e}, 64'd0);
    check({tag, "_data"}, 64'(q), 64'(exp_q.pop_front()));
  endtask

  initial begin
    int lat; int extra; logic e; logic [DW-1:0] q;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat", 64'(dat_out), 64'd0);
    check("rst_rdy", {63'd0, rdy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic write then read
    write_word("wr5", 26'h5, 32'h12345678);
    read_word("rd5", 26'h5, LAT);

    // out-of-range read
    write_word("wr0", 26'h0, 32'h0F0F1234);
    access(1'b1, 1'b0, 26'h100, '0, lat, e, q);
    check("miss_lat", 64'(lat), 64'(ERR_LAT));
    check("miss_err", {63'd0, e}, 64'd1);
    check("miss_data", 64'(q), 64'd0);
    read_word("rd0", 26'h0, LAT);

    // read and write both asserted
    write_word("wr3", 26'h3, 32'h33333333);
    access(1'b1, 1'b1, 26'h3, 32'hFFFFFFFF, lat, e, q);
    check("both_lat", 64'(lat), 64'(ERR_LAT));
    check("both_err", {63'd0, e}, 64'd1);
    check("both_data", 64'(q), 64'd0);
    read_word("rd3", 26'h3, LAT);

    // read held well past rdy
    exp_q.push_back(model[5]);
    @(negedge clk);
    mem_r = 1'b1; mem_adr = 26'h5;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rdy) begin lat = k; break; end
    end
    check("held_lat", 64'(lat), 64'(LAT));
    check("held_data", 64'(dat_out), 64'(exp_q.pop_front()));
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy) extra++;
      check("held_busy", {63'd0, busy}, 64'd1);
    end
    check("held_extra_rdy", 64'(extra), 64'd0);
    @(negedge clk);
    mem_r = 1'b0;
    @(posedge clk); #1;
    check("held_busy_drop", {63'd0, busy}, 64'd0);

    // reset in the middle of a write
    write_word("wr7", 26'h7, 32'hAAAA5555);
    @(negedge clk);
    mem_w = 1'b1; mem_adr = 26'h7; dat_in = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_dat", 64'(dat_out), 64'd0);
    check("abort_rdy", {63'd0, rdy}, 64'd0);
    check("abort_err", {63'd0, err}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_state", 64'(fsm_state), 64'd0);
    @(negedge clk);
    mem_w = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    read_word("rd7", 26'h7, LAT);

    // write immediately followed by a read of the same word
`ifdef MEM_POSTED_WR_EN
    access(1'b0, 1'b1, 26'h9, 32'hCAFEF00D, lat, e, q);
    check("post_wr_lat", 64'(lat), 64'd1);
    check("post_wr_err", {63'd0, e}, 64'd0);
    model[9] = 32'hCAFEF00D;
    read_word("post_rd9", 26'h9, 6);
`else
    write_word("wr9", 26'h9, 32'hCAFEF00D);
    read_word("rd9", 26'h9, LAT);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mem_ctrl.md
Name: wb_mem_ctrl

Overview:
- Memory-side stage directly downstream of the Wishbone slave.
- Consumes the slave's memory strobes (address, read, write) and data, and services them from an on-chip word-addressed SRAM array with programmable wait states.
- Returns read data and a ready/error handshake to the slave.
- Runs on the CMU-generated bus clock and is reset by the CMU clear output.

Parameters:
- ADDR_W, 26: address width, matches slave mem_adr_o.
- DATA_W, 32: data word width.
- DEPTH_LOG2, 8: log2 of array depth in words (256 words).
- BASE_ADDR, 26'h0000000: first word address decoded by this block.
- WAIT_STATES, 2: access wait cycles, legal range 0..15.

Ports:
- clk_i  in  1  bus clock.
- rst_i  in  1  asynchronous, active-high reset.
- mem_adr_i  in  ADDR_W  word address from slave.
- mem_r_i  in  1  read request, level, held until rdy_o.
- mem_w_i  in  1  write request, level, held until rdy_o.
- dat_i  in  DATA_W  write data, valid while mem_w_i is high.
- dat_o  out  DATA_W  registered read data.
- rdy_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle error pulse, coincident with rdy_o.
- busy_o  out  1  high whenever FSM not in IDLE (or a posted write is pending).

Behaviour:
- Reset is asynchronous, active-high, and fixed. While rst_i is high: state=IDLE, dat_o=0, rdy_o=0, err_o=0, busy_o=0, wait counter=0. Array contents are not reset.
- Reset mid-operation aborts the access. A write whose commit edge has not occurred is not committed; the old word remains.
- Address decode: hit iff BASE_ADDR <= mem_adr_i < BASE_ADDR + 2**DEPTH_LOG2. Index = (mem_adr_i - BASE_ADDR)[DEPTH_LOG2-1:0].
- FSM states: IDLE, SETUP, WAIT, DONE, RELEASE.
- IDLE: if mem_r_i or mem_w_i is high at edge N, latch address, data and op, then go to SETUP.
- SETUP: a single cycle. Check the request:
  - Protocol error if both mem_r_i and mem_w_i were sampled high.
  - Decode miss if the address is out of range.
  - On either error, go directly to DONE with err_o armed, and perform no array access.
  - Otherwise load the wait counter with WAIT_STATES and go to WAIT. If WAIT_STATES=0, go to DONE.
- WAIT: decrement the counter each cycle; go to DONE on the edge where the counter reaches 0.
- Array access happens on the edge entering DONE:
  - Write: array[index] <= latched data.
  - Read: dat_o <= array[index].
  - Error: dat_o <= 0.
- DONE: rdy_o=1 (and err_o=1 if armed) for exactly one cycle, then go to RELEASE.
- RELEASE: wait until mem_r_i and mem_w_i are both low, then go to IDLE. A request held high past rdy_o never triggers a second access.
- Latency: rdy_o is high in the cycle following edge N+2+WAIT_STATES. Error responses: following edge N+2.
- dat_o holds its value until the next completed read or error.

Optional Feature:
- Macro: MEM_POSTED_WR_EN.
- Enabled: a valid write is posted.
  - Address and data go to a one-entry post buffer at edge N.
  - rdy_o pulses in the cycle after edge N+1; the FSM then goes to RELEASE.
  - A background counter commits the write at edge N+2+WAIT_STATES.
  - While the post is pending: busy_o=1, and IDLE accepts no new request (it is held until after the commit edge).
  - A read of the same address after the commit returns the new data.
  - Error writes are not posted; they follow normal error timing.
- Disabled: writes follow the base FSM timing, and no post buffer is synthesised.

Test Plan:
- Write 32'h12345678 to address 26'h0000005, then read 26'h0000005 (WAIT_STATES=2) -> rdy_o after edge N+4 for each access; read dat_o=32'h12345678; err_o=0.
- Read address 26'h0000100 (out of range) -> after edge N+2: rdy_o=1, err_o=1, dat_o=0; a later read of 26'h0000000 returns its prior value.
- mem_r_i and mem_w_i both high at address 26'h0000003 -> err_o=1 with rdy_o; word 3 is unchanged on readback.
- Read request held high for 5 cycles after rdy_o -> exactly one rdy_o pulse; busy_o=1 until the request drops, then 0 one cycle later.
- Word 7 holds 32'hAAAA5555; assert rst_i during WAIT of a write of 32'h0 to address 7 -> all outputs 0 immediately without a clock edge; a later read of word 7 returns 32'hAAAA5555.
- With MEM_POSTED_WR_EN: write 32'hCAFEF00D to address 9, then read 9 immediately -> write rdy_o after edge N+1; the read is accepted only after the commit edge N+4; dat_o=32'hCAFEF00D.
